uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter TICK_DIV, default 651, meaning clk cycles per 1/16-bit oversample tick (100 MHz / (9600*16), truncated).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 rx  input  1  asynchronous serial line; idles high; 8N1 frame, LSB first.
REQ-005 rx_data  output  8  last correctly framed byte; held until the next good frame.
REQ-006 rx_done  output  1  one-cycle pulse, valid with rx_data; drives the command decoder's valid input.
REQ-007 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer (rx_s); the FSM SHALL use only rx_s; the synchronizer flops reset to 1.
REQ-010 Tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert tick for one clk when it equals TICK_DIV-1.
REQ-011 Tick counter SHALL be forced to 0 on the IDLE->START transition so that sampling phase is aligned to the detected edge.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP and BREAK; a 4-bit sample counter and a 3-bit bit index SHALL run alongside.
REQ-013 IDLE: when rx_s==0, go to START with sample counter=0; otherwise stay.
REQ-014 START: on each tick, increment the sample counter; at count 7, if rx_s==0 go to DATA with counter=0 and bit index=0; if rx_s==1 (glitch), return to IDLE with no pulse.
REQ-015 DATA: on each tick, increment; at count 15, shift rx_s into the MSB of the shift register (right shift), reset the counter to 0 and increment the bit index; after bit index 7, go to STOP.
REQ-016 STOP: at count 15 on a tick, if rx_s==1, load rx_data from the shift register, pulse rx_done and go to IDLE.
REQ-017 STOP: at count 15 on a tick, if rx_s==0, pulse frame_err, leave rx_data unchanged, no rx_done, and go to BREAK.
REQ-018 BREAK: stay until rx_s==1, then go to IDLE; a low line SHALL NOT start a new frame from BREAK.
REQ-019 rx_done and frame_err SHALL be registered, high for exactly one clk, and never high together.
REQ-020 Latency: rx_done SHALL rise 8+16*9 = 152 ticks (+/- one tick) after rx_s first samples low, measured from the tick-counter realignment.
REQ-021 A new start bit arriving immediately after the stop-bit sample (back-to-back frames) SHALL be detected from IDLE on the next cycle with no frame loss.
REQ-022 busy SHALL be combinationally derived as state != IDLE.

Reset
REQ-023 On rst, the FSM SHALL go to IDLE; counters and the shift register SHALL clear to 0; rx_data=8'h00, rx_done=0, frame_err=0, busy=0; synchronizer flops=1.
REQ-024 rst asserted mid-frame SHALL abort the frame with no pulse; reception resumes on the first falling edge after release.

Verification (TICK_DIV=4, so 64 clk per bit)
REQ-025 Send 0x52 ("R") 8N1 -> exactly one rx_done pulse with rx_data=8'h52; frame_err stays 0; busy falls on the same edge that rx_done rises.
REQ-026 Send 0x63 then 0x48 back-to-back with no idle gap -> two rx_done pulses, with rx_data 8'h63 then 8'h48.
REQ-027 Drive rx low for 16 clk (<half bit), then high -> FSM returns to IDLE; no rx_done and no frame_err.
REQ-028 Send 0x4D with the stop bit forced low, then hold low for 3 bit times, then release and send 0x73 -> one frame_err pulse, rx_data stays at its prior value during the error, no pulse while held low, then rx_done with 8'h73.
REQ-029 Assert rst for 2 clk during data bit 4 of 0x58 -> no pulse for that frame; all outputs return to their reset values; the following 0x78 is received correctly.
REQ-030 Send 0x00 and 0xFF -> rx_data 8'h00 and 8'hFF respectively; each frame produces exactly one rx_done.

Source files
------------

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Bundle of the serial input line and the received-byte
//                outputs of uart_rx.
//                  rx        : serial line, idles high (8N1, LSB first)
//                  rx_data   : last correctly framed byte
//                  rx_done   : one-clk pulse, valid with rx_data
//                  frame_err : one-clk pulse when the stop bit samples low
//                  busy      : receiver is inside a frame or a break
//                slave  modport : the receiver itself
//                master modport : line driver / byte consumer
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  modport slave  (input  rx, output rx_data, output rx_done, output frame_err, output busy);
  modport master (output rx, input  rx_data, input  rx_done, input  frame_err, input  busy);
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with 16x oversampling. The serial line is
//                synchronized, the start bit is validated at its centre, the
//                data bits and the stop bit are sampled at their centres.
//                A low stop bit reports a framing error and the receiver then
//                waits for the line to return high before re-arming.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - uart_rx_if.slave (rx in; rx_data, rx_done,
//                       frame_err, busy out)
//  Parameters  : TICK_DIV - clk cycles per 1/16-bit oversample tick
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int unsigned TICK_DIV = 651
) (
  input wire        clk,
  input wire        rst,
  uart_rx_if.slave  bus
);

  localparam int unsigned              c_TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_TICK_W-1:0]      c_TICK_MAX = c_TICK_W'(TICK_DIV - 1);
  localparam logic [c_TICK_W-1:0]      c_TICK_ONE = c_TICK_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // Synchronizer
  logic r_rx_meta;
  logic r_rx_s;

  // Oversample tick generator
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic                w_tick;
  logic                w_tick_clr;

  // FSM and datapath
  state_t     r_state,      w_state_nxt;
  logic [3:0] r_sample_cnt, w_sample_nxt;
  logic [2:0] r_bit_idx,    w_bit_nxt;
  logic [7:0] r_shift,      w_shift_nxt;
  logic [7:0] r_rx_data,    w_data_nxt;
  logic       r_rx_done,    w_done_nxt;
  logic       r_frame_err,  w_err_nxt;

  // The synchronizer idles high so that reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick = (r_tick_cnt == c_TICK_MAX);

  // Free-running divider, restarted on a detected falling edge so the
  // sample points land at fixed offsets from the start of the start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick_clr || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sample_cnt <= 4'd0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_rx_data    <= 8'h00;
      r_rx_done    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sample_cnt <= w_sample_nxt;
      r_bit_idx    <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_rx_data    <= w_data_nxt;
      r_rx_done    <= w_done_nxt;
      r_frame_err  <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sample_nxt = r_sample_cnt;
    w_bit_nxt    = r_bit_idx;
    w_shift_nxt  = r_shift;
    w_data_nxt   = r_rx_data;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_tick_clr   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt  = ST_START;
          w_sample_nxt = 4'd0;
          w_tick_clr   = 1'b1;
        end
      end

      // Start bit is re-checked half a bit in; a high line there was a glitch.
      ST_START: begin
        if (w_tick) begin
          if (r_sample_cnt == 4'd7) begin
            w_sample_nxt = 4'd0;
            if (!r_rx_s) begin
              w_state_nxt = ST_DATA;
              w_bit_nxt   = 3'd0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_sample_nxt = r_sample_cnt + 4'd1;
          end
        end
      end

      // LSB arrives first, so shifting right leaves bit 0 in place after 8.
      ST_DATA: begin
        if (w_tick) begin
          if (r_sample_cnt == 4'd15) begin
            w_sample_nxt = 4'd0;
            w_shift_nxt  = {r_rx_s, r_shift[7:1]};
            w_bit_nxt    = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              w_state_nxt = ST_STOP;
            end
          end else begin
            w_sample_nxt = r_sample_cnt + 4'd1;
          end
        end
      end

      ST_STOP: begin
        if (w_tick) begin
          if (r_sample_cnt == 4'd15) begin
            w_sample_nxt = 4'd0;
            if (r_rx_s) begin
              w_data_nxt  = r_shift;
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_BREAK;
            end
          end else begin
            w_sample_nxt = r_sample_cnt + 4'd1;
          end
        end
      end

      // A held-low line after a bad stop bit is a break, not a new start bit.
      ST_BREAK: begin
        if (r_rx_s) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_done   = r_rx_done;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx with TICK_DIV=4 (64 clk per
//                bit). Each driven frame pushes its expected outcome to a
//                scoreboard queue; a monitor pops and compares on every
//                rx_done / frame_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int c_BIT_CLKS = 64;
  localparam int c_LAT_NOM  = 611;  // clk from driven start edge to pulse
  localparam int c_LAT_TOL  = 5;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         start_cyc;
  } exp_t;

  logic clk;
  logic rst;
  uart_rx_if bus ();

  uart_rx #(.TICK_DIV(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         cyc;
  int         n_checks;
  int         n_pass;
  int         n_done_seen;
  int         n_done_exp;
  logic [7:0] last_good;
  exp_t       sb_q[$];
  exp_t       mon_e;
  logic       prev_busy;
  logic       prev_pulse;
  int         lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one full 8N1 frame starting at a negedge; stop=0 forces a bad stop bit.
  task automatic send_byte(input logic [7:0] d, input bit stop);
    exp_t e;
    e.is_err    = !stop;
    e.data      = stop ? d : last_good;
    e.start_cyc = cyc;
    sb_q.push_back(e);
    if (stop) begin
      last_good = d;
      n_done_exp++;
    end
    bus.rx = 1'b0;
    wait_clks(c_BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_clks(c_BIT_CLKS);
    end
    bus.rx = stop;
    wait_clks(c_BIT_CLKS);
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.rx_done || bus.frame_err)) begin
      check("done_err_excl", 32'(bus.rx_done & bus.frame_err), 0);
      check("pulse_1clk", 32'(prev_pulse), 0);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'({bus.rx_done, bus.frame_err}), 0);
      end else begin
        mon_e = sb_q.pop_front();
        lat   = cyc - mon_e.start_cyc;
        check("pulse_kind", 32'(bus.frame_err), 32'(mon_e.is_err));
        check("rx_data", 32'(bus.rx_data), 32'(mon_e.data));
        check("latency_in_window",
              32'((lat >= c_LAT_NOM - c_LAT_TOL) && (lat <= c_LAT_NOM + c_LAT_TOL)), 1);
        check("busy_before_pulse", 32'(prev_busy), 1);
        if (bus.rx_done) check("busy_fall_with_done", 32'(bus.busy), 0);
        else             check("busy_in_break", 32'(bus.busy), 1);
      end
      if (bus.rx_done) n_done_seen++;
    end
    prev_busy  = bus.busy;
    prev_pulse = bus.rx_done | bus.frame_err;
  end

  initial begin
    cyc         = 0;
    n_checks    = 0;
    n_pass      = 0;
    n_done_seen = 0;
    n_done_exp  = 0;
    last_good   = 8'h00;
    prev_busy   = 1'b0;
    prev_pulse  = 1'b0;
    rst         = 1'b1;
    bus.rx      = 1'b1;
    wait_clks(5);
    check("rst_rx_data", 32'(bus.rx_data), 0);
    check("rst_rx_done", 32'(bus.rx_done), 0);
    check("rst_frame_err", 32'(bus.frame_err), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    wait_clks(20);

    // Single frame
    send_byte(8'h52, 1'b1);
    wait_clks(40);

    // Back-to-back frames, no idle gap
    send_byte(8'h63, 1'b1);
    send_byte(8'h48, 1'b1);
    wait_clks(40);

    // Short low glitch must not start a frame
    bus.rx = 1'b0;
    wait_clks(16);
    bus.rx = 1'b1;
    wait_clks(c_BIT_CLKS);
    check("glitch_idle", 32'(bus.busy), 0);
    wait_clks(32);

    // Bad stop bit, then line held low as a break, then a good frame
    send_byte(8'h4D, 1'b0);
    wait_clks(3 * c_BIT_CLKS / 2);
    check("break_busy", 32'(bus.busy), 1);
    check("break_data_held", 32'(bus.rx_data), 32'(8'h48));
    wait_clks(3 * c_BIT_CLKS / 2);
    bus.rx = 1'b1;
    wait_clks(c_BIT_CLKS);
    check("break_released", 32'(bus.busy), 0);
    send_byte(8'h73, 1'b1);
    wait_clks(40);

    // Reset in the middle of data bit 4 of 0x58; frame abandoned afterwards
    bus.rx = 1'b0;
    wait_clks(c_BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      bus.rx = 1'(8'h58 >> i);
      wait_clks(c_BIT_CLKS);
    end
    bus.rx = 1'b1;
    wait_clks(c_BIT_CLKS / 2);
    rst = 1'b1;
    wait_clks(2);
    check("midrst_rx_data", 32'(bus.rx_data), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_pulses", 32'({bus.rx_done, bus.frame_err}), 0);
    rst = 1'b0;
    last_good = 8'h00;
    wait_clks(12 * c_BIT_CLKS);
    check("midrst_quiet", 32'(n_done_seen), 32'(n_done_exp));
    send_byte(8'h78, 1'b1);
    wait_clks(40);

    // Extreme data patterns
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);

    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    wait_clks(c_BIT_CLKS);
    check("done_count", 32'(n_done_seen), 32'(n_done_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
